ext_mem_arbiter: RTL and testbench
==================================

// Module: ext_mem_arbiter
// PURPOSE
//  Responder end of external_memory_if. Time-multiplexes NUM_PORTS effect
//  clients (delay, reverb post-delays, ...) onto one single-port synchronous
//  memory. Fair round-robin arbitration, Avalon-style waitrequest and
//  readdatavalid back to each client, fixed-latency read return routing.
//  Sits between the pedalboard mem_if array and the board memory primitive.
// PARAMETERS
//  NUM_PORTS   6   number of client ports (1..16)
//  AWIDTH      15  client word address width
//  DWIDTH      16  data width (audio sample)
//  RD_LATENCY  2   memory cycles from mem_re_o to valid mem_rdata_i (>=1)
//  PIDW        derived localparam = $clog2(NUM_PORTS), min 1
// PORTS
//  clk_i            in   1                  system clock
//  srst_i           in   1                  sync reset, active-high
//  read_i           in   NUM_PORTS          per-port read request
//  write_i          in   NUM_PORTS          per-port write request
//  address_i        in   NUM_PORTS*AWIDTH   per-port word address, port p at [p*AWIDTH +: AWIDTH]
//  writedata_i      in   NUM_PORTS*DWIDTH   per-port write data
//  waitrequest_o    out  NUM_PORTS          request not accepted this cycle
//  readdata_o       out  NUM_PORTS*DWIDTH   per-port read data, held between returns
//  readdatavalid_o  out  NUM_PORTS          1-cycle pulse, readdata_o[p] valid
//  mem_addr_o       out  PIDW+AWIDTH        memory address = {port_idx, address}
//  mem_we_o         out  1                  memory write strobe
//  mem_re_o         out  1                  memory read strobe
//  mem_wdata_o      out  DWIDTH             memory write data
//  mem_rdata_i      in   DWIDTH             memory read data
// BEHAVIOUR
//  - Request on port p: req[p] = read_i[p] | write_i[p]. Client holds the request
//    and address/data stable until waitrequest_o[p]==0 (accept edge).
//  - Grant (combinational): search from last_grant+1 upward with wrap to 0;
//    first port with req set wins. At most one grant per cycle.
//    waitrequest_o[p] = req[p] & ~grant[p]; 0 for idle ports.
//    last_grant updates only on a grant.
//  - Fairness: a continuously requesting port waits at most NUM_PORTS-1 cycles.
//  - read_i & write_i both set on one port: write performed, no read return.
//  - Command stage (registered): one cycle after accept, mem_we_o/mem_re_o,
//    mem_addr_o = {p, address}, mem_wdata_o driven for exactly one cycle. Strobes
//    are 0 in cycles with no grant. addr/wdata hold their last value when idle.
//  - Read return: shift register of depth 1+RD_LATENCY carries {valid, port_id}.
//    Read accepted at cycle T gives readdatavalid_o[p]=1 at T+1+RD_LATENCY.
//    readdata_o[p] is loaded from mem_rdata_i in that cycle and then held.
//    Other ports' readdata_o are untouched.
//  - Ordering: commands reach memory in acceptance order. The arbiter adds no
//    reordering. Same-address read-after-write semantics are the memory's.
//  - Back-to-back: one command per cycle sustained. Reads from different ports
//    return in issue order, one per cycle.
//  - Reset (srst_i=1): last_grant=NUM_PORTS-1, so port 0 has first priority.
//    Return pipeline flushed and outstanding reads dropped: no readdatavalid
//    for them after reset. readdatavalid_o=0, readdata_o=0, mem_we_o=0,
//    mem_re_o=0, mem_addr_o=0, mem_wdata_o=0.
//    During reset waitrequest_o = req and nothing is granted.
//  - Reset deasserted mid-burst: first post-reset grant follows the reset
//    priority. Clients re-issue any lost reads.
// TESTING
//  1 Single port: port 2 writes 0x1234 @0x0005, then reads it (RD_LATENCY=2)
//    -> mem_addr_o=0x10005 (PIDW=3); read accepted at T, readdatavalid_o[2] at
//    T+3, readdata_o[2]=0x1234.
//  2 All 6 ports request reads at cycle 0 after reset -> grants in order
//    0,1,2,3,4,5 on cycles 0..5; each port's waitrequest deasserts exactly at
//    its grant; valids on cycles 3..8 routed to matching ports.
//  3 Ports 1 and 4 hold continuous writes -> grants alternate 1,4,1,4;
//    neither waits more than 1 cycle; no idle memory cycles.
//  4 Port 3 asserts read_i and write_i together with data 0xBEEF -> one
//    mem_we_o pulse, no mem_re_o, no readdatavalid_o[3].
//  5 Reads issued at cycles 0,1; srst_i pulsed at cycle 2 -> no readdatavalid_o
//    on any port afterward; next grant goes to lowest requesting index.
//  6 Random traffic on all ports vs a reference memory model for 10k cycles
//    -> every read returns the model value; per-port wait <=5 cycles.

Source files
------------

// File: rtl/ext_mem_arbiter.sv
// Round-robin arbiter multiplexing NUM_PORTS Avalon-style clients onto one
// single-port synchronous memory, with fixed-latency read return routing.
module ext_mem_arbiter #(
    parameter int unsigned NUM_PORTS  = 6,
    parameter int unsigned AWIDTH     = 15,
    parameter int unsigned DWIDTH     = 16,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                              clk_i,
    input  logic                              srst_i,
    input  logic [NUM_PORTS-1:0]              read_i,
    input  logic [NUM_PORTS-1:0]              write_i,
    input  logic [NUM_PORTS*AWIDTH-1:0]       address_i,
    input  logic [NUM_PORTS*DWIDTH-1:0]       writedata_i,
    output logic [NUM_PORTS-1:0]              waitrequest_o,
    output logic [NUM_PORTS*DWIDTH-1:0]       readdata_o,
    output logic [NUM_PORTS-1:0]              readdatavalid_o,
    output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)+AWIDTH-1:0] mem_addr_o,
    output logic                              mem_we_o,
    output logic                              mem_re_o,
    output logic [DWIDTH-1:0]                 mem_wdata_o,
    input  logic [DWIDTH-1:0]                 mem_rdata_i
);

    localparam int unsigned PIDW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned PIPE_DEPTH = 1 + RD_LATENCY;

    logic [NUM_PORTS-1:0]      req;
    logic [NUM_PORTS-1:0]      grant;
    logic                      grant_any;
    logic [PIDW-1:0]           grant_idx;
    logic [PIDW-1:0]           last_grant;
    logic                      accept_read;
    logic                      accept_write;
    logic [AWIDTH-1:0]         sel_addr;
    logic [DWIDTH-1:0]         sel_wdata;

    logic [PIPE_DEPTH-1:0]     pipe_vld;
    logic [PIDW-1:0]           pipe_pid [PIPE_DEPTH];
    logic                      ret_valid;
    logic [PIDW-1:0]           ret_pid;
    logic [NUM_PORTS*DWIDTH-1:0] rd_hold;

    assign req = read_i | write_i;

    // Round-robin search starting just after the last granted port.
    always_comb begin : rr_search
        int unsigned cand;
        cand      = 0;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            cand = (32'(last_grant) + i) % NUM_PORTS;
            if (!grant_any && !srst_i && req[PIDW'(cand)]) begin
                grant_any = 1'b1;
                grant_idx = PIDW'(cand);
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign waitrequest_o = req & ~grant;

    // A combined read+write is treated as a write only.
    assign accept_write = grant_any & write_i[grant_idx];
    assign accept_read  = grant_any & read_i[grant_idx] & ~write_i[grant_idx];

    always_comb begin : cmd_select
        sel_addr  = '0;
        sel_wdata = '0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (grant[p]) begin
                sel_addr  = address_i[p*AWIDTH +: AWIDTH];
                sel_wdata = writedata_i[p*DWIDTH +: DWIDTH];
            end
        end
    end

    // Command stage: one registered memory command per accepted request.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            last_grant  <= PIDW'(NUM_PORTS - 1);
            mem_we_o    <= 1'b0;
            mem_re_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            mem_we_o <= accept_write;
            mem_re_o <= accept_read;
            if (grant_any) begin
                last_grant  <= grant_idx;
                mem_addr_o  <= {grant_idx, sel_addr};
                mem_wdata_o <= sel_wdata;
            end
        end
    end

    // Return pipeline tags each issued read with its port; reset drops them.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            pipe_vld <= '0;
            for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
                pipe_pid[k] <= '0;
            end
        end else begin
            pipe_vld    <= {pipe_vld[PIPE_DEPTH-2:0], accept_read};
            pipe_pid[0] <= grant_idx;
            for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
                pipe_pid[k] <= pipe_pid[k-1];
            end
        end
    end

    assign ret_valid = pipe_vld[PIPE_DEPTH-1] & ~srst_i;
    assign ret_pid   = pipe_pid[PIPE_DEPTH-1];

    always_comb begin : rdv_decode
        readdatavalid_o = '0;
        if (ret_valid) begin
            readdatavalid_o[ret_pid] = 1'b1;
        end
    end

    // Per-port read data: bypass in the return cycle, then held.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            rd_hold <= '0;
        end else begin
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                if (readdatavalid_o[p]) begin
                    rd_hold[p*DWIDTH +: DWIDTH] <= mem_rdata_i;
                end
            end
        end
    end

    always_comb begin : rdata_mux
        readdata_o = rd_hold;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (readdatavalid_o[p]) begin
                readdata_o[p*DWIDTH +: DWIDTH] = mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Bench for ext_mem_arbiter: vector table, directed corner sequences and
// random traffic against a client-side reference memory and latency model.
module tb_ext_mem_arbiter;

    localparam int unsigned NP   = 6;
    localparam int unsigned AW   = 15;
    localparam int unsigned DW   = 16;
    localparam int unsigned RL   = 2;
    localparam int unsigned MAW  = 18;

    logic              clk_i = 1'b0;
    logic              srst_i = 1'b1;
    logic [NP-1:0]     read_i = '0;
    logic [NP-1:0]     write_i = '0;
    logic [NP*AW-1:0]  address_i = '0;
    logic [NP*DW-1:0]  writedata_i = '0;
    logic [NP-1:0]     waitrequest_o;
    logic [NP*DW-1:0]  readdata_o;
    logic [NP-1:0]     readdatavalid_o;
    logic [MAW-1:0]    mem_addr_o;
    logic              mem_we_o;
    logic              mem_re_o;
    logic [DW-1:0]     mem_wdata_o;
    logic [DW-1:0]     mem_rdata_i = '0;

    ext_mem_arbiter #(.NUM_PORTS(NP), .AWIDTH(AW), .DWIDTH(DW), .RD_LATENCY(RL)) dut (
        .clk_i(clk_i), .srst_i(srst_i), .read_i(read_i), .write_i(write_i),
        .address_i(address_i), .writedata_i(writedata_i),
        .waitrequest_o(waitrequest_o), .readdata_o(readdata_o),
        .readdatavalid_o(readdatavalid_o), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 50)
                $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Memory primitive: RL-cycle read latency, unwritten words hold a fixed pattern.
    logic [DW-1:0] mem [int];
    logic [DW-1:0] rpipe [RL+1];

    function automatic logic [DW-1:0] init_val(input int a);
        logic [31:0] t;
        t = 32'(a) * 32'h9E37_79B1;
        return t[23:8] ^ 16'h5A5A;
    endfunction

    function automatic logic [DW-1:0] mem_rd(input int a);
        if (mem.exists(a)) return mem[a];
        return init_val(a);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
        for (int k = RL; k >= 1; k--) rpipe[k] = rpipe[k-1];
        rpipe[0] = mem_re_o ? mem_rd(int'(mem_addr_o)) : DW'($urandom);
        if (mem_we_o) mem[int'(mem_addr_o)] = mem_wdata_o;
        mem_rdata_i = rpipe[RL];
        cyc++;
    endtask

    task automatic clear_inputs();
        read_i = '0;
        write_i = '0;
    endtask

    task automatic set_port(input int p, input logic rd, input logic wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        read_i[p] = rd;
        write_i[p] = wr;
        address_i[p*AW +: AW] = a;
        writedata_i[p*DW +: DW] = d;
    endtask

    task automatic apply_reset();
        tick();
        clear_inputs();
        srst_i = 1'b1;
        tick();
        srst_i = 1'b0;
        @(negedge clk_i);
    endtask

    typedef struct {
        logic [NP-1:0] rd;
        logic [NP-1:0] wr;
        logic [NP-1:0] exp_wait;
        logic [NP-1:0] exp_rdv;
        logic          exp_we;
        logic          exp_re;
    } vec_t;
    vec_t tbl [21];

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t rq [NP][$];

    logic          act [NP];
    logic          op_rd [NP];
    logic          op_wr [NP];
    logic [AW-1:0] op_addr [NP];
    logic [DW-1:0] op_data [NP];
    int            wcnt [NP];
    logic [DW-1:0] shadow [NP][16];
    logic          pc_we, pc_re;
    logic [MAW-1:0] pc_addr;
    logic [DW-1:0] pc_data;
    bit            draining;

    // One random-traffic cycle: drive clients, then score outputs at the falling edge.
    task automatic rand_cycle();
        logic [NP-1:0] req, gnt;
        int r;
        exp_t e;
        tick();
        for (int p = 0; p < int'(NP); p++) begin
            if (!act[p] && !draining && $urandom_range(99) < 60) begin
                act[p] = 1'b1;
                r = int'($urandom_range(9));
                op_rd[p] = (r < 5) || (r == 9);
                op_wr[p] = (r >= 5);
                op_addr[p] = AW'($urandom_range(15));
                op_data[p] = DW'($urandom);
            end
            set_port(p, act[p] & op_rd[p], act[p] & op_wr[p], op_addr[p], op_data[p]);
        end
        @(negedge clk_i);
        req = read_i | write_i;
        gnt = req & ~waitrequest_o;
        check("rand_strobes", {62'd0, mem_we_o, mem_re_o}, {62'd0, pc_we, pc_re});
        if (pc_we || pc_re) begin
            check("rand_cmd_addr", 64'(mem_addr_o), 64'(pc_addr));
            if (pc_we) check("rand_cmd_wdata", 64'(mem_wdata_o), 64'(pc_data));
        end
        check("rand_idle_wait", 64'(waitrequest_o & ~req), 64'd0);
        check("rand_grant_cnt", 64'($countones(gnt)), (req != 0) ? 64'd1 : 64'd0);
        for (int p = 0; p < int'(NP); p++) begin
            if (readdatavalid_o[p]) begin
                if (rq[p].size() == 0) begin
                    check("rand_spurious_rdv", 64'(p), 64'hFF);
                end else begin
                    e = rq[p].pop_front();
                    check("rand_rdata", 64'(readdata_o[p*DW +: DW]), 64'(e.data));
                    check("rand_rd_latency", 64'(cyc), 64'(e.due));
                end
            end
        end
        pc_we = 1'b0;
        pc_re = 1'b0;
        for (int p = 0; p < int'(NP); p++) begin
            if (act[p] && gnt[p]) begin
                pc_addr = MAW'((p << AW) | int'(op_addr[p]));
                pc_data = op_data[p];
                if (op_wr[p]) begin
                    shadow[p][op_addr[p][3:0]] = op_data[p];
                    pc_we = 1'b1;
                end else begin
                    e.data = shadow[p][op_addr[p][3:0]];
                    e.due = cyc + int'(RL) + 1;
                    rq[p].push_back(e);
                    pc_re = 1'b1;
                end
                check("rand_max_wait", 64'(wcnt[p] > int'(NP) - 1), 64'd0);
                wcnt[p] = 0;
                act[p] = 1'b0;
            end else if (act[p]) begin
                wcnt[p]++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k <= int'(RL); k++) rpipe[k] = '0;

        // Reset behaviour: waitrequest mirrors requests, outputs cleared.
        tick();
        srst_i = 1'b1;
        read_i = 6'b101101;
        write_i = 6'b000010;
        @(negedge clk_i);
        check("reset_wait_eq_req", 64'(waitrequest_o), 64'h2F);
        tick();
        clear_inputs();
        @(negedge clk_i);
        check("reset_rdv", 64'(readdatavalid_o), 64'd0);
        tick();
        srst_i = 1'b0;
        @(negedge clk_i);
        check("reset_readdata", 64'(readdata_o), 64'd0);
        check("reset_strobes", {62'd0, mem_we_o, mem_re_o}, 64'd0);
        check("reset_addr", 64'(mem_addr_o), 64'd0);
        check("reset_wdata", 64'(mem_wdata_o), 64'd0);

        // Arbitration vectors: all-port reads, alternating writers, read+write.
        tbl[0]  = '{6'h3F, 6'h00, 6'h3E, 6'h00, 1'b0, 1'b0};
        tbl[1]  = '{6'h3E, 6'h00, 6'h3C, 6'h00, 1'b0, 1'b1};
        tbl[2]  = '{6'h3C, 6'h00, 6'h38, 6'h00, 1'b0, 1'b1};
        tbl[3]  = '{6'h38, 6'h00, 6'h30, 6'h01, 1'b0, 1'b1};
        tbl[4]  = '{6'h30, 6'h00, 6'h20, 6'h02, 1'b0, 1'b1};
        tbl[5]  = '{6'h20, 6'h00, 6'h00, 6'h04, 1'b0, 1'b1};
        tbl[6]  = '{6'h00, 6'h00, 6'h00, 6'h08, 1'b0, 1'b1};
        tbl[7]  = '{6'h00, 6'h00, 6'h00, 6'h10, 1'b0, 1'b0};
        tbl[8]  = '{6'h00, 6'h00, 6'h00, 6'h20, 1'b0, 1'b0};
        tbl[9]  = '{6'h00, 6'h00, 6'h00, 6'h00, 1'b0, 1'b0};
        tbl[10] = '{6'h00, 6'h12, 6'h10, 6'h00, 1'b0, 1'b0};
        tbl[11] = '{6'h00, 6'h12, 6'h02, 6'h00, 1'b1, 1'b0};
        tbl[12] = '{6'h00, 6'h12, 6'h10, 6'h00, 1'b1, 1'b0};
        tbl[13] = '{6'h00, 6'h12, 6'h02, 6'h00, 1'b1, 1'b0};
        tbl[14] = '{6'h00, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0};
        tbl[15] = '{6'h00, 6'h00, 6'h00, 6'h00, 1'b0, 1'b0};
        tbl[16] = '{6'h08, 6'h08, 6'h00, 6'h00, 1'b0, 1'b0};
        tbl[17] = '{6'h00, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0};
        tbl[18] = '{6'h00, 6'h00, 6'h00, 6'h00, 1'b0, 1'b0};
        tbl[19] = '{6'h00, 6'h00, 6'h00, 6'h00, 1'b0, 1'b0};
        tbl[20] = '{6'h00, 6'h00, 6'h00, 6'h00, 1'b0, 1'b0};
        for (int i = 0; i < 21; i++) begin
            tick();
            for (int p = 0; p < int'(NP); p++)
                set_port(p, tbl[i].rd[p], tbl[i].wr[p], AW'(p), DW'(p * 16'h1111));
            @(negedge clk_i);
            check($sformatf("vec%0d_wait", i), 64'(waitrequest_o), 64'(tbl[i].exp_wait));
            check($sformatf("vec%0d_rdv", i), 64'(readdatavalid_o), 64'(tbl[i].exp_rdv));
            check($sformatf("vec%0d_strobes", i), {62'd0, mem_we_o, mem_re_o},
                  {62'd0, tbl[i].exp_we, tbl[i].exp_re});
            for (int p = 0; p < int'(NP); p++)
                if (tbl[i].exp_rdv[p])
                    check($sformatf("vec%0d_rdata", i), 64'(readdata_o[p*DW +: DW]),
                          64'(init_val((p << AW) | p)));
        end

        // Port 2 writes 0x1234 @5 then reads it back.
        tick();
        clear_inputs();
        set_port(2, 1'b0, 1'b1, 15'h0005, 16'h1234);
        @(negedge clk_i);
        check("t1_wr_wait", 64'(waitrequest_o), 64'd0);
        tick();
        clear_inputs();
        set_port(2, 1'b1, 1'b0, 15'h0005, 16'h0000);
        @(negedge clk_i);
        check("t1_we", {62'd0, mem_we_o, mem_re_o}, 64'h2);
        check("t1_addr", 64'(mem_addr_o), 64'h10005);
        check("t1_wdata", 64'(mem_wdata_o), 64'h1234);
        check("t1_rd_wait", 64'(waitrequest_o), 64'd0);
        tick();
        clear_inputs();
        @(negedge clk_i);
        check("t1_re", {62'd0, mem_we_o, mem_re_o}, 64'h1);
        check("t1_re_addr", 64'(mem_addr_o), 64'h10005);
        tick();
        @(negedge clk_i);
        check("t1_rdv_early", 64'(readdatavalid_o), 64'd0);
        tick();
        @(negedge clk_i);
        check("t1_rdv", 64'(readdatavalid_o), 64'h04);
        check("t1_rdata", 64'(readdata_o[2*DW +: DW]), 64'h1234);
        tick();
        @(negedge clk_i);
        check("t1_rdv_after", 64'(readdatavalid_o), 64'd0);
        check("t1_rdata_hold", 64'(readdata_o[2*DW +: DW]), 64'h1234);

        // Reset in flight drops outstanding reads; port 0 priority restored.
        apply_reset();
        tick();
        for (int p = 0; p < int'(NP); p++) set_port(p, (p == 0 || p == 1 || p == 3), 1'b0, AW'(p), '0);
        @(negedge clk_i);
        check("t5_wait_c0", 64'(waitrequest_o), 64'h0A);
        tick();
        read_i[0] = 1'b0;
        @(negedge clk_i);
        check("t5_wait_c1", 64'(waitrequest_o), 64'h08);
        tick();
        srst_i = 1'b1;
        read_i = '0;
        write_i = 6'h28;
        @(negedge clk_i);
        check("t5_wait_reset", 64'(waitrequest_o), 64'h28);
        check("t5_rdv_reset", 64'(readdatavalid_o), 64'd0);
        tick();
        srst_i = 1'b0;
        @(negedge clk_i);
        check("t5_wait_post", 64'(waitrequest_o), 64'h20);
        check("t5_strobes_post", {62'd0, mem_we_o, mem_re_o}, 64'd0);
        check("t5_rdv_c3", 64'(readdatavalid_o), 64'd0);
        for (int i = 4; i < 10; i++) begin
            tick();
            if (i == 4) write_i[3] = 1'b0;
            if (i == 5) clear_inputs();
            @(negedge clk_i);
            check($sformatf("t5_rdv_c%0d", i), 64'(readdatavalid_o), 64'd0);
        end

        // Random traffic against the reference model.
        apply_reset();
        for (int p = 0; p < int'(NP); p++) begin
            act[p] = 1'b0;
            op_rd[p] = 1'b0;
            op_wr[p] = 1'b0;
            op_addr[p] = '0;
            op_data[p] = '0;
            wcnt[p] = 0;
            for (int a = 0; a < 16; a++) shadow[p][a] = mem_rd((p << AW) | a);
        end
        pc_we = 1'b0;
        pc_re = 1'b0;
        pc_addr = '0;
        pc_data = '0;
        draining = 1'b0;
        for (int i = 0; i < 10000; i++) rand_cycle();
        draining = 1'b1;
        for (int i = 0; i < 40; i++) rand_cycle();
        for (int p = 0; p < int'(NP); p++) begin
            check($sformatf("drain_pending_p%0d", p), 64'(rq[p].size()), 64'd0);
            check($sformatf("drain_active_p%0d", p), 64'(act[p]), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
